// File: rtl/cmp_pkg.sv
// Shared constants for the cmp core: widths, instruction field ranges, opcodes and ALU functions.
// Bit numbering is big-endian: bit 0 is the MSB of every vector.
package cmp_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int ALEN = 32;
  localparam int NREG = 32;

  localparam int OP_HI  = 0;
  localparam int OP_LO  = 5;
  localparam int RD_HI  = 6;
  localparam int RD_LO  = 10;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 15;
  localparam int RB_HI  = 16;
  localparam int RB_LO  = 20;
  localparam int IMM_HI = 16;
  localparam int IMM_LO = 31;
  localparam int FN_HI  = 26;
  localparam int FN_LO  = 31;

  typedef enum logic [5:0] {
    OP_HALT = 6'b000000,
    OP_ALU  = 6'b101010,
    OP_LD   = 6'b100000,
    OP_SD   = 6'b100001,
    OP_BEZ  = 6'b100010,
    OP_BNEZ = 6'b100011
  } op_e;

  typedef enum logic [5:0] {
    FN_AND = 6'b000001,
    FN_OR  = 6'b000010,
    FN_XOR = 6'b000011,
    FN_NOT = 6'b000100,
    FN_MOV = 6'b000101,
    FN_ADD = 6'b000110,
    FN_SUB = 6'b000111,
    FN_SLL = 6'b001000,
    FN_SRL = 6'b001001
  } fn_e;

endpackage

// File: rtl/cmp_if.sv
// Instruction/data memory bus of the cmp core; the core is the master, the memories the slave.
interface cmp_if;
  import cmp_pkg::*;

  logic [0:ILEN-1] inst_in;
  logic [0:XLEN-1] d_in;
  logic [0:ALEN-1] pc_out;
  logic [0:XLEN-1] d_out;
  logic [0:ALEN-1] addr_out;
  logic            memWrEn;
  logic            memEn;

  modport master (
    input  inst_in, d_in,
    output pc_out, d_out, addr_out, memWrEn, memEn
  );

  modport slave (
    output inst_in, d_in,
    input  pc_out, d_out, addr_out, memWrEn, memEn
  );

endinterface

// File: rtl/cmp_regfile.sv
// 32x64 register file: two combinational read ports, one write port, R0 hardwired to zero.
// A read of the register being written this cycle returns the old value.
module cmp_regfile
  import cmp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra_addr_i,
  output logic [0:XLEN-1] ra_data_o,
  input  logic [4:0]      rb_addr_i,
  output logic [0:XLEN-1] rb_data_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [0:XLEN-1] wd_i
);

  logic [0:XLEN-1] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == 5'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == 5'd0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/cmp_core.sv
// Single-issue 64-bit cmp core: one instruction per clock, ALU and next-PC logic live here.
// Build option CMP_HALT_EN: when defined the all-zero word halts the core, otherwise it is a NOP.
module cmp_core
  import cmp_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  cmp_if.master bus
);

  logic [0:ALEN-1] pc_q, pc_d;
  logic            halted_q, halted_d;

  op_e             op;
  fn_e             fn;
  logic [4:0]      rd, ra, rb;
  logic [0:15]     imm;
  logic            halt_word;

  logic [4:0]      rb_sel;
  logic [0:XLEN-1] a_val, b_val, alu_res, wdata;
  logic            alu_ok, rf_we, mem_en, wr_en;

  assign op  = op_e'(bus.inst_in[OP_HI:OP_LO]);
  assign fn  = fn_e'(bus.inst_in[FN_HI:FN_LO]);
  assign rd  = bus.inst_in[RD_HI:RD_LO];
  assign ra  = bus.inst_in[RA_HI:RA_LO];
  assign rb  = bus.inst_in[RB_HI:RB_LO];
  assign imm = bus.inst_in[IMM_HI:IMM_LO];

`ifdef CMP_HALT_EN
  assign halt_word = (bus.inst_in == '0);
`else
  assign halt_word = 1'b0;
`endif

  // Second read port serves rB for ALU ops and rD for stores and branches.
  assign rb_sel = (op == OP_ALU) ? rb : rd;

  cmp_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (ra),
    .ra_data_o (a_val),
    .rb_addr_i (rb_sel),
    .rb_data_o (b_val),
    .we_i      (rf_we),
    .wa_i      (rd),
    .wd_i      (wdata)
  );

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (fn)
      FN_AND:  alu_res = a_val & b_val;
      FN_OR:   alu_res = a_val | b_val;
      FN_XOR:  alu_res = a_val ^ b_val;
      FN_NOT:  alu_res = ~a_val;
      FN_MOV:  alu_res = a_val;
      FN_ADD:  alu_res = a_val + b_val;
      FN_SUB:  alu_res = a_val - b_val;
      FN_SLL:  alu_res = a_val << b_val[58:63];
      FN_SRL:  alu_res = a_val >> b_val[58:63];
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q + 32'd4;
    halted_d = halted_q;
    rf_we    = 1'b0;
    wdata    = alu_res;
    mem_en   = 1'b0;
    wr_en    = 1'b0;
    if (halted_q) begin
      pc_d = pc_q;
    end else if (halt_word) begin
      pc_d     = pc_q;
      halted_d = 1'b1;
    end else begin
      case (op)
        OP_ALU: rf_we = alu_ok;
        OP_LD: begin
          mem_en = 1'b1;
          rf_we  = 1'b1;
          wdata  = bus.d_in;
        end
        OP_SD: begin
          mem_en = 1'b1;
          wr_en  = 1'b1;
        end
        OP_BEZ:  if (b_val == '0) pc_d = {16'h0, imm};
        OP_BNEZ: if (b_val != '0) pc_d = {16'h0, imm};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Enables are gated by reset so no access leaks out while reset is asserted.
  assign bus.memEn    = mem_en & ~reset;
  assign bus.memWrEn  = mem_en & wr_en & ~reset;
  assign bus.addr_out = bus.memEn ? {16'h0, imm} : '0;
  assign bus.d_out    = bus.memWrEn ? b_val : '0;
  assign bus.pc_out   = pc_q;

endmodule

// File: tb/tb_cmp_core.sv
// Self-checking bench for cmp_core: directed programs plus random programs, run in lockstep
// against an instruction-level reference model. Follows CMP_HALT_EN when it is defined.
module tb_cmp_core;

`ifdef CMP_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [5:0] C_ALU = 6'h2A, C_LD = 6'h20, C_SD = 6'h21, C_BEZ = 6'h22, C_BNEZ = 6'h23;
  localparam int F_AND = 1, F_OR = 2, F_XOR = 3, F_NOT = 4, F_MOV = 5,
                 F_ADD = 6, F_SUB = 7, F_SLL = 8, F_SRL = 9;

  logic clk, reset;
  cmp_if bus ();

  cmp_core dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] imem [256];
  logic [63:0] dmem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [63:0] pre_d;

  assign bus.inst_in = imem[bus.pc_out[22:29]];
  assign bus.d_in    = bus.memEn ? dmem[bus.addr_out[24:31]] : 64'h0;

  always @(posedge clk) begin
    if (pre_we) dmem[pre_a] <= pre_d;
    else if (bus.memEn && bus.memWrEn) dmem[bus.addr_out[24:31]] <= bus.d_out;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state stepped one instruction at a time.
  logic [31:0] m_pc;
  logic [63:0] m_regs [32];
  logic [63:0] m_dmem [256];
  bit          m_halted;

  function automatic logic [63:0] rr(input int x);
    return (x == 0) ? 64'h0 : m_regs[x];
  endfunction

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int ra, input int rb);
    return (32'(C_ALU) << 26) | (32'(rd) << 21) | (32'(ra) << 16) | (32'(rb) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int imm);
    return (32'(op) << 26) | (32'(rd) << 21) | (32'(imm) & 32'hFFFF);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_halted = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
  endtask

  task automatic model_step();
    logic [31:0] w, npc;
    logic [63:0] a, b, r;
    int rd, ra, rb, fn, imm;
    bit ok;
    w = imem[(m_pc >> 2) % 256];
    if (m_halted) return;
    rd = int'((w >> 21) % 32); ra = int'((w >> 16) % 32); rb = int'((w >> 11) % 32);
    imm = int'(w % 65536); fn = int'(w % 64);
    npc = m_pc + 32'd4;
    if (HALT_EN && w == 32'h0) begin
      m_halted = 1'b1;
      npc = m_pc;
    end else begin
      case (w >> 26)
        32'(C_ALU): begin
          a = rr(ra); b = rr(rb); ok = 1'b1; r = 64'h0;
          case (fn)
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_XOR: r = a ^ b;
            F_NOT: r = ~a;
            F_MOV: r = a;
            F_ADD: r = a + b;
            F_SUB: r = a - b;
            F_SLL: r = a << (b % 64);
            F_SRL: r = a >> (b % 64);
            default: ok = 1'b0;
          endcase
          if (ok && rd != 0) m_regs[rd] = r;
        end
        32'(C_LD):   if (rd != 0) m_regs[rd] = m_dmem[imm % 256];
        32'(C_SD):   m_dmem[imm % 256] = rr(rd);
        32'(C_BEZ):  if (rr(rd) == 0) npc = 32'(imm);
        32'(C_BNEZ): if (rr(rd) != 0) npc = 32'(imm);
        default: ;
      endcase
    end
    m_pc = npc;
  endtask

  // Called at a falling edge: checks outputs for the current instruction, then steps the model.
  task automatic run(input int n);
    logic [31:0] w;
    bit is_ld, is_sd;
    repeat (n) begin
      #1;
      w = imem[(m_pc >> 2) % 256];
      is_ld = !m_halted && ((w >> 26) == 32'(C_LD));
      is_sd = !m_halted && ((w >> 26) == 32'(C_SD));
      chk("pc", bus.pc_out, m_pc);
      chk("memEn", bus.memEn, is_ld || is_sd);
      chk("memWrEn", bus.memWrEn, is_sd);
      chk("addr", bus.addr_out, (is_ld || is_sd) ? 64'(w % 65536) : 64'h0);
      if (is_sd) chk("d_out", bus.d_out, rr(int'((w >> 21) % 32)));
      else if (!is_ld) chk("d_out_idle", bus.d_out, 64'h0);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic poke(input int a, input logic [63:0] d);
    pre_a = 8'(a); pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    m_dmem[a] = d;
  endtask

  task automatic set_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    foreach (p[i]) imem[i] = p[i];
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    model_reset();
    reset = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) chk(tag, dmem[i], m_dmem[i]);
  endtask

  initial begin
    logic [31:0] p[$];
    logic [31:0] pc0;
    int r;
    reset = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) poke(i, 64'h0);

    // Reset held 4 cycles with a load program present: no access may escape.
    p = '{enc_i(C_LD, 1, 16'h10), enc_i(C_LD, 2, 16'h11), enc_r(F_ADD, 3, 1, 2),
          enc_i(C_SD, 3, 16'h20), 32'h0};
    set_prog(p);
    poke(16, 64'd5);
    poke(17, 64'd7);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_pc", bus.pc_out, 64'h0);
      chk("rst_memEn", bus.memEn, 64'h0);
      chk("rst_memWrEn", bus.memWrEn, 64'h0);
    end
    release_reset();
    run(5);
    chk("sum_store", dmem[32], 64'h000000000000000C);
    pc0 = bus.pc_out;
    run(10);
    chk("halt_pc", bus.pc_out, HALT_EN ? 64'h10 : 64'(pc0) + 64'd40);
    chk("halt_memEn", bus.memEn, 64'h0);

    // Carry discard, subtraction and shift edges.
    hold_reset();
    poke(0, 64'hFFFF_FFFF_FFFF_FFFF);
    poke(1, 64'd1);
    poke(2, 64'd63);
    p = '{enc_i(C_LD, 1, 0), enc_i(C_LD, 2, 1), enc_i(C_LD, 8, 2),
          enc_r(F_ADD, 5, 1, 2), enc_r(F_SUB, 6, 1, 2), enc_r(F_SLL, 7, 2, 8),
          enc_r(F_SRL, 11, 1, 8), enc_r(F_XOR, 12, 1, 7),
          enc_i(C_SD, 5, 16'h40), enc_i(C_SD, 6, 16'h41), enc_i(C_SD, 7, 16'h42),
          enc_i(C_SD, 11, 16'h43), enc_i(C_SD, 12, 16'h44), 32'h0};
    set_prog(p);
    release_reset();
    run(16);
    chk("add_wrap", dmem[8'h40], 64'h0);
    chk("sub", dmem[8'h41], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sll63", dmem[8'h42], 64'h8000_0000_0000_0000);
    chk("srl63", dmem[8'h43], 64'h1);
    chk("xor", dmem[8'h44], 64'h7FFF_FFFF_FFFF_FFFF);

    // Countdown loop: body runs exactly three times then falls through.
    hold_reset();
    poke(3, 64'd3);
    p = '{enc_i(C_LD, 4, 3), enc_i(C_LD, 9, 1), enc_r(F_SUB, 4, 4, 9),
          enc_r(F_ADD, 10, 10, 9), enc_i(C_BNEZ, 4, 8),
          enc_i(C_SD, 10, 16'h50), enc_i(C_SD, 4, 16'h51), 32'h0};
    set_prog(p);
    release_reset();
    run(18);
    chk("loop_count", dmem[8'h50], 64'd3);
    chk("loop_final", dmem[8'h51], 64'd0);

    // R0 ignores writes; a taken BEZ on R0 skips a store.
    hold_reset();
    poke(8'h60, 64'hDEAD_BEEF_0000_0001);
    poke(8'h61, 64'h55);
    p = '{enc_i(C_LD, 0, 1), enc_i(C_LD, 1, 0), enc_r(F_ADD, 0, 1, 1),
          enc_i(C_SD, 0, 16'h60), enc_i(C_BEZ, 0, 24), enc_i(C_SD, 1, 16'h61), 32'h0};
    set_prog(p);
    release_reset();
    run(10);
    chk("r0_store", dmem[8'h60], 64'h0);
    chk("bez_skip", dmem[8'h61], 64'h55);

    // Random programs against the model.
    for (int it = 0; it < 6; it++) begin
      hold_reset();
      for (int a = 0; a < 16; a++) poke(a, {$urandom, $urandom});
      p = {};
      for (int i = 0; i < 32; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 50)
          p.push_back(enc_r(int'($urandom_range(0, 11)), int'($urandom_range(0, 15)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
        else if (r < 65) p.push_back(enc_i(C_LD, int'($urandom_range(0, 15)), int'($urandom_range(0, 31))));
        else if (r < 80) p.push_back(enc_i(C_SD, int'($urandom_range(0, 15)), int'($urandom_range(0, 31))));
        else if (r < 90) p.push_back(enc_i(($urandom_range(0, 1) != 0) ? C_BEZ : C_BNEZ,
                                           int'($urandom_range(0, 15)), int'($urandom_range(0, 31)) * 4));
        else if (r < 96) p.push_back($urandom);
        else p.push_back(32'h0);
      end
      set_prog(p);
      release_reset();
      run(60);
      chk_mem("rand_mem", 0, 31);
    end

    // Reset mid-run: outputs drop at once and no write is left pending.
    hold_reset();
    for (int a = 0; a < 8; a++) poke(a, {$urandom, $urandom});
    p = {};
    for (int i = 0; i < 24; i++)
      p.push_back((i % 2 == 0) ? enc_i(C_LD, 1 + (i % 7), i % 8) : enc_i(C_SD, 1 + (i % 5), (i % 8) + 8));
    set_prog(p);
    release_reset();
    run(11);
    reset = 1'b1;
    #1;
    chk("midrst_pc", bus.pc_out, 64'h0);
    chk("midrst_memEn", bus.memEn, 64'h0);
    chk("midrst_memWrEn", bus.memWrEn, 64'h0);
    chk("midrst_addr", bus.addr_out, 64'h0);
    chk("midrst_dout", bus.d_out, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk_mem("midrst_mem", 0, 15);
    release_reset();
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
